// File: rtl/codec_frame_driver.sv
// Codec-side frame driver: paces the music player with new_frame and serializes the returned
// mono sample MSB-first into a 32-bit stereo frame (bit clock, L/R sync, data).
module codec_frame_driver #(
   parameter int CLKS_PER_HALF_BIT = 32,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [15:0]    sample_in,
   input  logic                  mute,
   output logic                  new_frame,
   output logic                  bit_clk_out,
   output logic                  sync_out,
   output logic                  sdata_out,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

   logic [HW-1:0] half_cnt;
   logic          phase;
   logic [4:0]    bit_idx;
   logic [31:0]   shreg;

   logic half_end;
   logic bit_end;
   logic frame_end;

   assign half_end  = (half_cnt == HALF_LAST);
   assign bit_end   = half_end && phase;
   assign frame_end = bit_end && (bit_idx == 5'd31);

   always_ff @(posedge clk) begin
      if (reset) begin
         half_cnt    <= '0;
         phase       <= 1'b0;
         bit_idx     <= '0;
         shreg       <= '0;
         new_frame   <= 1'b0;
         frame_count <= '0;
      end else begin
         new_frame <= frame_end;
         if (half_end) begin
            half_cnt <= '0;
            phase    <= ~phase;
         end else begin
            half_cnt <= half_cnt + HW'(1);
         end
         // Loads and shifts happen as bit_clk falls, so data is stable across the rising edge
         if (frame_end) begin
            bit_idx     <= '0;
            shreg       <= mute ? 32'h0 : {sample_in, sample_in};
            frame_count <= frame_count + CNT_WIDTH'(1);
         end else if (bit_end) begin
            bit_idx <= bit_idx + 5'd1;
            shreg   <= {shreg[30:0], 1'b0};
         end
      end
   end

   assign bit_clk_out = phase;
   assign sync_out    = bit_idx[4];
   assign sdata_out   = shreg[31];

endmodule
